store_serializer: RTL and testbench
===================================

STORE_SERIALIZER -- requirements
Module: store_serializer

Interface
REQ-001 Parameter ADDR_W, default 32, width of request and memory byte address.
REQ-002 Clock is one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req_valid  in  1  store request present.
REQ-006 req_ready  out  1  block can accept a request this cycle.
REQ-007 req_addr  in  ADDR_W  byte address of store.
REQ-008 req_data  in  32  register value to be stored (truncated per size).
REQ-009 req_size  in  2  00 byte (SB), 01 halfword (SH), 10 word (SW), 11 illegal.
REQ-010 mem_we  out  1  byte write strobe to byte-wide memory.
REQ-011 mem_addr  out  ADDR_W  byte address of current write.
REQ-012 mem_wdata  out  8  byte being written.
REQ-013 mem_ack  in  1  memory accepted the byte presented this cycle.
REQ-014 done  out  1  one-cycle pulse, store fully written.
REQ-015 err  out  1  one-cycle pulse, request rejected (illegal size or misaligned).

Function
REQ-016 Block SHALL narrow a 32-bit register value to 1, 2 or 4 bytes (the inverse of immediate/load extension) and serialize them onto the byte bus.
REQ-017 States SHALL be IDLE, SEND, DONE, ERR.
REQ-018 IDLE: req_ready=1, mem_we=0, done=0, err=0.
REQ-019 Handshake SHALL be req_valid && req_ready on a rising edge; req_* sampled only then; inputs ignored in all other cycles.
REQ-020 On accept, illegal if req_size==11, or size 01 with addr[0]!=0, or size 10 with addr[1:0]!=00; illegal -> ERR, nothing written.
REQ-021 On legal accept, block SHALL latch addr, data, last index (0/1/3), clear byte index to 0, go SEND.
REQ-022 SEND: req_ready=0, mem_we=1, mem_addr=latched addr+index, mem_wdata=latched data[8*index+7 : 8*index] (little-endian, byte 0 = data[7:0]).
REQ-023 SEND with mem_ack=0 SHALL hold mem_addr, mem_wdata, mem_we stable.
REQ-024 SEND with mem_ack=1: if index==last go DONE, else index+1, stay SEND.
REQ-025 Address addition SHALL be modulo 2^ADDR_W (wrap, no flag).
REQ-026 DONE: done=1, mem_we=0, req_ready=0 for exactly one cycle, then IDLE.
REQ-027 ERR: err=1, mem_we=0, req_ready=0 for exactly one cycle, then IDLE.
REQ-028 Latency with mem_ack held 1: SB done 2 cycles after accept, SH 3, SW 5; each extra mem_ack=0 cycle adds one.
REQ-029 Upper bytes beyond size SHALL never appear on mem_wdata with mem_we=1.
REQ-030 done and err SHALL never assert in the same cycle; back-to-back request accepted in first IDLE cycle after DONE/ERR.

Reset
REQ-031 rst=1 SHALL force IDLE next edge from any state, abandoning a partial store (already-acked bytes stay written).
REQ-032 Reset values: req_ready=1 after reset edge, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0, index=0.
REQ-033 rst takes priority over req_valid and mem_ack in the same cycle.

Verification
REQ-034 SW addr 0x100 data 0xAABBCCDD, mem_ack=1 -> writes 0x100=DD, 0x101=CC, 0x102=BB, 0x103=AA, done 5 cycles after accept.
REQ-035 SB addr 0x203 data 0x12345678 -> single write 0x203=78, done 2 cycles after accept, no other mem_we.
REQ-036 SH addr 0x10 data 0xFFFF8001, mem_ack low 3 cycles on first byte -> 0x10=01 held stable 4 cycles, then 0x11=80, done.
REQ-037 SW addr 0x102, and separately size 11 -> err pulse 1 cycle after accept, mem_we never 1, req_ready back next cycle.
REQ-038 SW addr 0xFFFFFFFE rejected; SH addr 0xFFFFFFFE -> writes 0xFFFFFFFE, 0xFFFFFFFF; SB at 0xFFFFFFFF no wrap fault.
REQ-039 rst asserted during SW after 2 bytes acked -> next cycle IDLE, mem_we=0, no done pulse, new SB accepted normally.

Source files
------------

// File: rtl/store_serializer_if.sv
// Store request and byte-wide memory write bus for store_serializer.
// The slave side is the serializer. The master side is the requester and memory.
// A request transfers on a rising edge with req_valid && req_ready, and req_* is ignored otherwise.
// A byte write completes on a rising edge with mem_we && mem_ack, and mem_* holds until that edge.
interface store_serializer_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_data;
    logic [1:0]        req_size;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ack;
    logic              done;
    logic              err;

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_ack,
        output req_ready, mem_we, mem_addr, mem_wdata, done, err
    );

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_ack,
        input  req_ready, mem_we, mem_addr, mem_wdata, done, err
    );
endinterface

// File: rtl/store_serializer.sv
// Narrows a 32-bit register value to an SB/SH/SW store and writes it
// little-endian, one byte per acknowledged cycle, onto a byte-wide memory bus.
module store_serializer #(
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    store_serializer_if.slave   bus,
    output logic [1:0]          state_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t            state_q;
    logic [1:0]        idx_q;
    logic [1:0]        last_q;
    logic [31:0]       data_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              mem_we_q;
    logic              req_ready_q;
    logic              done_q;
    logic              err_q;

    logic       accept;
    logic       illegal;
    logic [1:0] last_d;
    logic [1:0] idx_d;

    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] i);
        return w[8*i +: 8];
    endfunction

    assign accept = bus.req_valid && req_ready_q;
    assign idx_d  = idx_q + 2'd1;

    // Halfwords need even addresses and words need 4-byte alignment.
    always_comb begin
        illegal = 1'b0;
        last_d  = 2'd0;
        case (bus.req_size)
            2'b00: begin
                last_d = 2'd0;
            end
            2'b01: begin
                last_d  = 2'd1;
                illegal = bus.req_addr[0];
            end
            2'b10: begin
                last_d  = 2'd3;
                illegal = (bus.req_addr[1:0] != 2'b00);
            end
            default: begin
                last_d  = 2'd0;
                illegal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            last_q      <= 2'd0;
            data_q      <= 32'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'd0;
            mem_we_q    <= 1'b0;
            req_ready_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        if (illegal) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q     <= SEND;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= bus.req_addr;
                            data_q      <= bus.req_data;
                            mem_wdata_q <= bus.req_data[7:0];
                            idx_q       <= 2'd0;
                            last_q      <= last_d;
                        end
                    end
                end
                // The byte bus stays frozen until the memory acknowledges it.
                // mem_addr tracks base + index, so it wraps modulo 2^ADDR_W.
                SEND: begin
                    if (bus.mem_ack) begin
                        if (idx_q == last_q) begin
                            state_q  <= DONE;
                            mem_we_q <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            idx_q       <= idx_d;
                            mem_addr_q  <= mem_addr_q + 1'b1;
                            mem_wdata_q <= pick_byte(data_q, idx_d);
                        end
                    end
                end
                DONE, ERR: begin
                    state_q     <= IDLE;
                    done_q      <= 1'b0;
                    err_q       <= 1'b0;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    mem_we_q    <= 1'b0;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_store_serializer.sv
// Directed scoreboard bench for store_serializer: expected byte writes and
// done/err pulses (with their cycle numbers) are queued and matched by a monitor.
module tb_store_serializer;
    localparam int ADDR_W = 32;
    localparam logic [1:0] EV_NONE = 2'd0, EV_DONE = 2'd1, EV_ERR = 2'd2;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state;

    store_serializer_if #(.ADDR_W(ADDR_W)) bus ();

    store_serializer #(.ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state)
    );

    always #5 clk = ~clk;

    // ---------------- clock bookkeeping ----------------
    logic [31:0] cyc = 32'd0;
    logic        rst_at_edge = 1'b1;
    always @(posedge clk) begin
        cyc         <= cyc + 32'd1;
        rst_at_edge <= rst;
    end

    // ---------------- scoreboard state ----------------
    logic [ADDR_W+7:0] exp_q[$];
    logic [33:0]       exp_ev_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    logic mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // ---------------- memory acknowledge driver ----------------
    int   stall_set  = 0;
    int   budget_set = 1000000;
    logic cfg_tog    = 1'b0;
    logic cfg_seen   = 1'b0;
    int   stall_left = 0;
    int   budget_left = 1000000;

    initial begin
        bus.mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (cfg_tog != cfg_seen) begin
                cfg_seen    = cfg_tog;
                stall_left  = stall_set;
                budget_left = budget_set;
            end
            if (bus.mem_we) begin
                if (stall_left > 0) begin
                    bus.mem_ack = 1'b0;
                    stall_left--;
                end else if (budget_left > 0) begin
                    bus.mem_ack = 1'b1;
                    budget_left--;
                end else begin
                    bus.mem_ack = 1'b0;
                end
            end else begin
                bus.mem_ack = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic cfg_ack(input int stall, input int budget);
        stall_set  = stall;
        budget_set = budget;
        cfg_tog    = ~cfg_tog;
    endtask

    // ---------------- monitor ----------------
    logic              prev_stall = 1'b0;
    logic [ADDR_W-1:0] prev_addr  = '0;
    logic [7:0]        prev_data  = 8'd0;
    logic              ready_due  = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.done && bus.err) fail("done_err_overlap");
            if (ready_due) check("ready_after_pulse", 64'(bus.req_ready), 64'd1);
            ready_due = bus.done || bus.err;
            if (bus.mem_we && bus.req_ready) fail("we_with_ready");
            if (prev_stall && !rst_at_edge) begin
                check("hold_we", 64'(bus.mem_we), 64'd1);
                check("hold_addr", 64'(bus.mem_addr), 64'(prev_addr));
                check("hold_data", 64'(bus.mem_wdata), 64'(prev_data));
            end
            prev_stall = bus.mem_we && !bus.mem_ack;
            prev_addr  = bus.mem_addr;
            prev_data  = bus.mem_wdata;
            if (bus.mem_we && bus.mem_ack) begin
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h", bus.mem_addr, bus.mem_wdata);
                    n_checks++;
                    n_fail++;
                end else begin
                    check("write", 64'({bus.mem_addr, bus.mem_wdata}), 64'(exp_q.pop_front()));
                end
            end
            if (bus.done || bus.err) begin
                if (exp_ev_q.size() == 0) begin
                    $display("FAIL unexpected_event: done %0b err %0b", bus.done, bus.err);
                    n_checks++;
                    n_fail++;
                end else begin
                    check("event_kind_cycle", 64'({(bus.err ? EV_ERR : EV_DONE), cyc}),
                          64'(exp_ev_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic exp_wr(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic do_req(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                          input logic [1:0] size, input logic [1:0] kind, input int lat);
        int guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            fail("req_ready_timeout");
        end else begin
            bus.req_valid = 1'b1;
            bus.req_addr  = addr;
            bus.req_data  = data;
            bus.req_size  = size;
            if (kind != EV_NONE) exp_ev_q.push_back({kind, cyc + 32'(lat)});
            @(negedge clk);
            bus.req_valid = 1'b0;
            bus.req_addr  = $urandom;
            bus.req_data  = $urandom;
            bus.req_size  = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic wait_quiet();
        int guard = 0;
        while ((exp_q.size() != 0 || exp_ev_q.size() != 0) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            fail("completion_timeout");
            exp_q.delete();
            exp_ev_q.delete();
        end
    endtask

    // ---------------- directed tests ----------------
    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = 32'd0;
        bus.req_size  = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_mem_we", 64'(bus.mem_we), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        check("rst_state", 64'(state), 64'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // SW, ack always high
        cfg_ack(0, 1000000);
        exp_wr(32'h100, 8'hDD);
        exp_wr(32'h101, 8'hCC);
        exp_wr(32'h102, 8'hBB);
        exp_wr(32'h103, 8'hAA);
        do_req(32'h100, 32'hAABBCCDD, 2'b10, EV_DONE, 5);
        wait_quiet();

        // SB at odd address, only low byte written
        exp_wr(32'h203, 8'h78);
        do_req(32'h203, 32'h12345678, 2'b00, EV_DONE, 2);
        wait_quiet();

        // SH with three stalled cycles on byte 0
        cfg_ack(3, 1000000);
        exp_wr(32'h10, 8'h01);
        exp_wr(32'h11, 8'h80);
        do_req(32'h10, 32'hFFFF8001, 2'b01, EV_DONE, 6);
        wait_quiet();
        cfg_ack(0, 1000000);

        // Rejections: misaligned SW, illegal size, misaligned SH
        do_req(32'h102, 32'h11223344, 2'b10, EV_ERR, 1);
        wait_quiet();
        do_req(32'h200, 32'h11223344, 2'b11, EV_ERR, 1);
        wait_quiet();
        do_req(32'h11, 32'h0000BEEF, 2'b01, EV_ERR, 1);
        wait_quiet();

        // Top of address space
        do_req(32'hFFFFFFFE, 32'hDEADBEEF, 2'b10, EV_ERR, 1);
        wait_quiet();
        exp_wr(32'hFFFFFFFE, 8'hEF);
        exp_wr(32'hFFFFFFFF, 8'hBE);
        do_req(32'hFFFFFFFE, 32'h0000BEEF, 2'b01, EV_DONE, 3);
        wait_quiet();
        exp_wr(32'hFFFFFFFF, 8'h5A);
        do_req(32'hFFFFFFFF, 32'hCAFEBA5A, 2'b00, EV_DONE, 2);
        wait_quiet();

        // Back-to-back: second request queued behind the first
        exp_wr(32'h40, 8'h33);
        exp_wr(32'h44, 8'h04);
        exp_wr(32'h45, 8'h03);
        exp_wr(32'h46, 8'h02);
        exp_wr(32'h47, 8'h01);
        do_req(32'h40, 32'h00000033, 2'b00, EV_DONE, 2);
        do_req(32'h44, 32'h01020304, 2'b10, EV_DONE, 5);
        wait_quiet();

        // Reset in the middle of a SW after two acknowledged bytes
        cfg_ack(0, 2);
        exp_wr(32'h300, 8'h11);
        exp_wr(32'h301, 8'h22);
        do_req(32'h300, 32'h44332211, 2'b10, EV_NONE, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_mem_we", 64'(bus.mem_we), 64'd0);
        check("midrst_req_ready", 64'(bus.req_ready), 64'd1);
        check("midrst_done", 64'(bus.done), 64'd0);
        check("midrst_state", 64'(state), 64'd0);
        check("midrst_partial_writes", 64'(exp_q.size()), 64'd0);
        cfg_ack(0, 1000000);
        exp_wr(32'h304, 8'h99);
        do_req(32'h304, 32'h00000099, 2'b00, EV_DONE, 2);
        wait_quiet();

        repeat (4) @(negedge clk);
        check("final_write_queue", 64'(exp_q.size()), 64'd0);
        check("final_event_queue", 64'(exp_ev_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
